// File: rtl/bubble_output_engine_pkg.sv
// rtl/bubble_output_engine_pkg.sv - shared access codes, tick constant and FSM state type
// for the bubble output engine.
package bubble_output_engine_pkg;

  localparam logic [2:0] ACC_IDLE = 3'd0;
  localparam logic [2:0] ACC_BOOT = 3'd1;
  localparam logic [2:0] ACC_PAGE = 3'd2;

  localparam logic [1:0] TICK_DATA = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  // Reserved codes behave like ACC_IDLE: they never start or sustain an access.
  function automatic logic is_access(input logic [2:0] acc);
    return (acc == ACC_BOOT) || (acc == ACC_PAGE);
  endfunction

endpackage

// File: rtl/bubble_output_engine_if.sv
// rtl/bubble_output_engine_if.sv - timing-generator, load-port and output signals
// of the bubble output engine.
interface bubble_output_engine_if #(
  parameter int CHANNELS = 2,
  parameter int CYCLEW   = 13
);
  logic [2:0]          acctype;
  logic [CYCLEW-1:0]   boutcyclenum;
  logic [1:0]          boutticks;
  logic                nswapen;
  logic                noutbufwclken;
  logic [CYCLEW+1:0]   outbufwaddr;
  logic                outbufwdata;
  logic                loaddone;
  logic [CHANNELS-1:0] dout;
  logic                rdbank;
  logic                flippend;
  logic                rangeerr;

  modport master (
    output acctype, boutcyclenum, boutticks, nswapen,
    output noutbufwclken, outbufwaddr, outbufwdata, loaddone,
    input  dout, rdbank, flippend, rangeerr
  );

  modport slave (
    input  acctype, boutcyclenum, boutticks, nswapen,
    input  noutbufwclken, outbufwaddr, outbufwdata, loaddone,
    output dout, rdbank, flippend, rangeerr
  );
endinterface

// File: rtl/bubble_bank_ram.sv
// rtl/bubble_bank_ram.sv - dual-bank buffer, one bit-plane per channel, single-bit write
// port and registered CHANNELS-bit read port.
module bubble_bank_ram #(
  parameter int CHANNELS = 2,
  parameter int AW       = 12
) (
  input  logic                clk,
  input  logic                we,
  input  logic                wbank,
  input  logic [AW-1:0]       waddr,
  input  logic [1:0]          wch,
  input  logic                wbit,
  input  logic                rbank,
  input  logic [AW-1:0]       raddr,
  output logic [CHANNELS-1:0] rdata
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_plane
    logic mem [2**(AW+1)];

    always_ff @(posedge clk) begin
      if (we && (wch == 2'(c))) begin
        mem[{wbank, waddr}] <= wbit;
      end
      rdata[c] <= mem[{rbank, raddr}];
    end
  end

endmodule

// File: rtl/bubble_output_engine.sv
// rtl/bubble_output_engine.sv - double-buffered bubble data output: loads one bank while
// the other is streamed to DOUT during data phases, with deferred bank flips.
module bubble_output_engine
  import bubble_output_engine_pkg::*;
#(
  parameter int   CHANNELS   = 2,
  parameter int   CYCLEW     = 13,
  parameter int   DEPTH      = 4096,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic                    mclk,
  input logic                    rst,
  bubble_output_engine_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e state_q, state_d;
  logic   flush_cnt_q;
  logic   flush_done;

  logic   rdbank_q, flippend_q, rangeerr_q;
  logic   flip;

  logic [1:0]        wch;
  logic [CYCLEW-1:0] wcyc;
  logic              wen;

  logic              samp, inrange;
  logic [AW-1:0]     s0_addr;
  logic              s0_valid, s0_swap;
  logic              s1_valid, s1_swap;

  logic [CHANNELS-1:0] rdata, rdata_rev, dout_q;

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      ST_IDLE:   if (is_access(bus.acctype)) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!is_access(bus.acctype)) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (flush_cnt_q) begin
          flush_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Flips only land in IDLE, so the read bank is frozen for a whole access and its drain.
  assign flip = ((state_q == ST_IDLE) && bus.loaddone) ||
                (flush_done && (flippend_q || bus.loaddone));

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 1'b0;
      rdbank_q    <= 1'b0;
      flippend_q  <= 1'b0;
      rangeerr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= (state_q == ST_FLUSH) ? ~flush_cnt_q : 1'b0;
      rdbank_q    <= rdbank_q ^ flip;
      if (flush_done) begin
        flippend_q <= 1'b0;
      end else if ((state_q != ST_IDLE) && bus.loaddone) begin
        flippend_q <= 1'b1;
      end
      if (samp && !inrange) begin
        rangeerr_q <= 1'b1;
      end
    end
  end

  assign wch  = bus.outbufwaddr[1:0];
  assign wcyc = bus.outbufwaddr[CYCLEW+1:2];
  assign wen  = !bus.noutbufwclken && (32'(wch) < CHANNELS) && (32'(wcyc) < DEPTH);

  assign samp    = (state_q == ST_ACTIVE) && (bus.boutticks == TICK_DATA);
  assign inrange = 32'(bus.boutcyclenum) < DEPTH;

  bubble_bank_ram #(
    .CHANNELS (CHANNELS),
    .AW       (AW)
  ) u_ram (
    .clk   (mclk),
    .we    (wen),
    .wbank (~rdbank_q),
    .waddr (wcyc[AW-1:0]),
    .wch   (wch),
    .wbit  (bus.outbufwdata),
    .rbank (rdbank_q),
    .raddr (s0_addr),
    .rdata (rdata)
  );

  for (genvar g = 0; g < CHANNELS; g++) begin : g_rev
    assign rdata_rev[g] = rdata[CHANNELS-1-g];
  end

  // Three stages: sample address/swap, RAM read, output register.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      s0_addr  <= '0;
      s0_valid <= 1'b0;
      s0_swap  <= 1'b0;
      s1_valid <= 1'b0;
      s1_swap  <= 1'b0;
      dout_q   <= {CHANNELS{IDLE_LEVEL}};
    end else begin
      s0_addr  <= bus.boutcyclenum[AW-1:0];
      s0_valid <= samp && inrange;
      s0_swap  <= !bus.nswapen;
      s1_valid <= s0_valid;
      s1_swap  <= s0_swap;
      if (s1_valid) begin
        dout_q <= s1_swap ? rdata_rev : rdata;
      end else begin
        dout_q <= {CHANNELS{IDLE_LEVEL}};
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.rdbank   = rdbank_q;
  assign bus.flippend = flippend_q;
  assign bus.rangeerr = rangeerr_q;

endmodule

// File: tb/tb_bubble_output_engine.sv
// tb/tb_bubble_output_engine.sv - directed self-checking bench for bubble_output_engine,
// 2-channel (DEPTH 4096) and 4-channel (DEPTH 16) instances.
module tb_bubble_output_engine;
  import bubble_output_engine_pkg::*;

  logic mclk = 1'b0;
  logic rst2 = 1'b1;
  logic rst4 = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [1:0] q2[$];
  logic [3:0] q4[$];
  logic       exp_bank;

  always #5 mclk = ~mclk;

  bubble_output_engine_if #(.CHANNELS(2), .CYCLEW(13)) b2 ();
  bubble_output_engine_if #(.CHANNELS(4), .CYCLEW(13)) b4 ();

  bubble_output_engine #(.CHANNELS(2), .CYCLEW(13), .DEPTH(4096), .IDLE_LEVEL(1'b1)) u2 (
    .mclk (mclk),
    .rst  (rst2),
    .bus  (b2)
  );

  bubble_output_engine #(.CHANNELS(4), .CYCLEW(13), .DEPTH(16), .IDLE_LEVEL(1'b1)) u4 (
    .mclk (mclk),
    .rst  (rst4),
    .bus  (b4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr2(input int cyc, input int ch, input logic d);
    b2.noutbufwclken = 1'b0;
    b2.outbufwaddr   = 15'(cyc * 4 + ch);
    b2.outbufwdata   = d;
    @(negedge mclk);
    b2.noutbufwclken = 1'b1;
  endtask

  task automatic wr4(input int cyc, input int ch, input logic d);
    b4.noutbufwclken = 1'b0;
    b4.outbufwaddr   = 15'(cyc * 4 + ch);
    b4.outbufwdata   = d;
    @(negedge mclk);
    b4.noutbufwclken = 1'b1;
  endtask

  task automatic pulse2();
    b2.loaddone = 1'b1;
    @(negedge mclk);
    b2.loaddone = 1'b0;
  endtask

  // One data phase: expected word queued at drive time, popped when DOUT is due.
  task automatic phase2(input string tag, input int cyc, input logic nsw, input logic [1:0] exp);
    b2.boutcyclenum = 13'(cyc);
    b2.nswapen      = nsw;
    b2.boutticks    = TICK_DATA;
    q2.push_back(exp);
    @(negedge mclk);
    b2.boutticks = 2'd0;
    @(negedge mclk);
    @(negedge mclk);
    check(tag, 32'(b2.dout), 32'(q2.pop_front()));
    @(negedge mclk);
    check({tag, "_idle"}, 32'(b2.dout), 32'h3);
  endtask

  task automatic phase4(input string tag, input int cyc, input logic nsw, input logic [3:0] exp);
    b4.boutcyclenum = 13'(cyc);
    b4.nswapen      = nsw;
    b4.boutticks    = TICK_DATA;
    q4.push_back(exp);
    @(negedge mclk);
    b4.boutticks = 2'd0;
    @(negedge mclk);
    @(negedge mclk);
    check(tag, 32'(b4.dout), 32'(q4.pop_front()));
    @(negedge mclk);
  endtask

  initial begin
    b2.acctype = ACC_IDLE; b2.boutcyclenum = '0; b2.boutticks = 2'd0; b2.nswapen = 1'b1;
    b2.noutbufwclken = 1'b1; b2.outbufwaddr = '0; b2.outbufwdata = 1'b0; b2.loaddone = 1'b0;
    b4.acctype = ACC_IDLE; b4.boutcyclenum = '0; b4.boutticks = 2'd0; b4.nswapen = 1'b1;
    b4.noutbufwclken = 1'b1; b4.outbufwaddr = '0; b4.outbufwdata = 1'b0; b4.loaddone = 1'b0;

    repeat (2) @(negedge mclk);
    check("rst_dout", 32'(b2.dout), 32'h3);
    check("rst_rdbank", 32'(b2.rdbank), 32'h0);
    check("rst_flippend", 32'(b2.flippend), 32'h0);
    check("rst_rangeerr", 32'(b2.rangeerr), 32'h0);
    check("rst4_dout", 32'(b4.dout), 32'hf);
    rst2 = 1'b0;
    rst4 = 1'b0;
    @(negedge mclk);

    // Load bank 1: cycle 5 = {ch1=0, ch0=1}, cycle 0 = 0; out-of-range writes must not alias.
    wr2(5, 0, 1'b1);
    wr2(5, 1, 1'b0);
    wr2(0, 0, 1'b0);
    wr2(0, 1, 1'b0);
    wr2(4096, 0, 1'b1);
    wr2(4096, 1, 1'b1);
    wr2(5, 2, 1'b1);
    wr2(5, 3, 1'b0);
    pulse2();
    exp_bank = 1'b1;
    check("flip_idle", 32'(b2.rdbank), 32'(exp_bank));

    b2.acctype = ACC_PAGE;
    @(negedge mclk);
    phase2("read_c5", 5, 1'b1, 2'b01);
    phase2("read_c5_swap", 5, 1'b0, 2'b10);
    phase2("read_c0_noalias", 0, 1'b1, 2'b00);

    // New data for cycle 5 goes to the load bank and must not disturb this access.
    wr2(5, 0, 1'b0);
    wr2(5, 1, 1'b1);
    phase2("read_c5_isolated", 5, 1'b1, 2'b01);

    pulse2();
    check("flippend_set", 32'(b2.flippend), 32'h1);
    check("rdbank_held", 32'(b2.rdbank), 32'(exp_bank));
    pulse2();
    b2.acctype = ACC_IDLE;
    @(negedge mclk);
    @(negedge mclk);
    check("flush_rdbank_held", 32'(b2.rdbank), 32'(exp_bank));
    check("flush_flippend_held", 32'(b2.flippend), 32'h1);
    @(negedge mclk);
    exp_bank = ~exp_bank;
    check("deferred_flip", 32'(b2.rdbank), 32'(exp_bank));
    check("flippend_clear", 32'(b2.flippend), 32'h0);
    @(negedge mclk);
    check("no_accum_flip", 32'(b2.rdbank), 32'(exp_bank));

    b2.acctype = ACC_PAGE;
    @(negedge mclk);
    phase2("read_newbank", 5, 1'b1, 2'b10);
    check("rangeerr_clear", 32'(b2.rangeerr), 32'h0);
    phase2("read_range", 4096, 1'b1, 2'b11);
    check("rangeerr_set", 32'(b2.rangeerr), 32'h1);

    b2.acctype = ACC_IDLE;
    repeat (3) @(negedge mclk);
    b2.acctype = ACC_BOOT;
    @(negedge mclk);
    check("rangeerr_sticky", 32'(b2.rangeerr), 32'h1);

    // LOADDONE landing exactly on the FLUSH->IDLE edge.
    b2.acctype = ACC_IDLE;
    @(negedge mclk);
    @(negedge mclk);
    b2.loaddone = 1'b1;
    @(negedge mclk);
    b2.loaddone = 1'b0;
    exp_bank = ~exp_bank;
    check("coincide_flip", 32'(b2.rdbank), 32'(exp_bank));
    check("coincide_flippend", 32'(b2.flippend), 32'h0);
    @(negedge mclk);
    check("coincide_single", 32'(b2.rdbank), 32'(exp_bank));

    // A reserved code leaves the FSM in IDLE, so LOADDONE flips immediately.
    b2.acctype = 3'd5;
    @(negedge mclk);
    pulse2();
    exp_bank = ~exp_bank;
    check("reserved_idle_flip", 32'(b2.rdbank), 32'(exp_bank));
    check("reserved_flippend", 32'(b2.flippend), 32'h0);
    b2.acctype = ACC_IDLE;

    // Four channels: pattern 1010 at cycle 0.
    wr4(0, 0, 1'b0);
    wr4(0, 1, 1'b1);
    wr4(0, 2, 1'b0);
    wr4(0, 3, 1'b1);
    b4.loaddone = 1'b1;
    @(negedge mclk);
    b4.loaddone = 1'b0;
    check("c4_flip", 32'(b4.rdbank), 32'h1);
    b4.acctype = ACC_PAGE;
    @(negedge mclk);
    phase4("c4_read", 0, 1'b1, 4'b1010);
    phase4("c4_read_swap", 0, 1'b0, 4'b0101);
    phase4("c4_read_range", 16, 1'b1, 4'b1111);
    check("c4_rangeerr", 32'(b4.rangeerr), 32'h1);

    b4.boutcyclenum = 13'd0;
    b4.nswapen      = 1'b1;
    b4.boutticks    = TICK_DATA;
    repeat (3) @(negedge mclk);
    check("c4_pre_rst", 32'(b4.dout), 32'ha);
    #2;
    rst4 = 1'b1;
    #1;
    check("c4_rst_dout", 32'(b4.dout), 32'hf);
    check("c4_rst_rdbank", 32'(b4.rdbank), 32'h0);
    check("c4_rst_rangeerr", 32'(b4.rangeerr), 32'h0);
    @(negedge mclk);
    b4.boutticks = 2'd0;
    b4.acctype   = ACC_IDLE;
    rst4 = 1'b0;
    @(negedge mclk);
    b4.loaddone = 1'b1;
    @(negedge mclk);
    b4.loaddone = 1'b0;
    check("c4_restart_flip", 32'(b4.rdbank), 32'h1);
    check("c4_restart_dout", 32'(b4.dout), 32'hf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
